// File: rtl/smi_self_link_serializer.sv
// SELF link width down-converter: one wide word in, 1..Ratio narrow beats out.
// Beats leave least significant first; EOF rides on the final beat only.
module smi_self_link_serializer #(
    parameter int DataWidth      = 8,
    parameter int Ratio          = 4,
    parameter int RatioIndexSize = 2
) (
    input  logic                          clk,
    input  logic                          srst,
    input  logic                          dataInValid,
    input  logic [DataWidth*Ratio-1:0]    dataIn,
    input  logic [RatioIndexSize-1:0]     dataInBeats,
    input  logic                          dataInEof,
    output logic                          dataInStop,
    output logic                          dataOutValid,
    output logic [DataWidth-1:0]          dataOut,
    output logic                          dataOutEof,
    input  logic                          dataOutStop
);

    localparam int WordWidth = DataWidth * Ratio;
    localparam logic [RatioIndexSize-1:0] CntOne = RatioIndexSize'(1);

    logic                      r_in_valid;
    logic [WordWidth-1:0]      r_in_word;
    logic [RatioIndexSize-1:0] r_in_beats;
    logic                      r_in_eof;

    logic                      r_sh_valid;
    logic [WordWidth-1:0]      r_sh_word;
    logic [RatioIndexSize-1:0] r_sh_cnt;
    logic                      r_sh_eof;

    logic                      r_out_valid;
    logic [DataWidth-1:0]      r_out_data;
    logic                      r_out_eof;

    logic w_in_stop;
    logic w_out_free;
    logic w_move;
    logic w_cnt_zero;
    logic w_sh_last;
    logic w_load;

    assign w_in_stop  = r_in_valid & r_sh_valid;
    assign w_out_free = ~(r_out_valid & dataOutStop);
    assign w_move     = r_sh_valid & w_out_free;
    assign w_cnt_zero = (r_sh_cnt == '0);
    assign w_sh_last  = w_move & w_cnt_zero;
    // The shifter refills on the same edge its last beat departs
    assign w_load     = r_in_valid & (~r_sh_valid | w_sh_last);

    always_ff @(posedge clk) begin
        if (!w_in_stop) begin
            r_in_word  <= dataIn;
            r_in_beats <= dataInBeats;
            r_in_eof   <= dataInEof;
        end
        if (srst) begin
            r_in_valid <= 1'b0;
        end else if (!w_in_stop) begin
            r_in_valid <= dataInValid;
        end else if (w_load) begin
            r_in_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (w_load) begin
            r_sh_word <= r_in_word;
            r_sh_cnt  <= r_in_beats;
            r_sh_eof  <= r_in_eof;
        end else if (w_move) begin
            r_sh_word <= r_sh_word >> DataWidth;
            if (!w_cnt_zero) begin
                r_sh_cnt <= r_sh_cnt - CntOne;
            end
        end
        if (srst) begin
            r_sh_valid <= 1'b0;
        end else if (w_load) begin
            r_sh_valid <= 1'b1;
        end else if (w_sh_last) begin
            r_sh_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (w_move) begin
            r_out_data <= r_sh_word[DataWidth-1:0];
        end
        if (srst) begin
            r_out_valid <= 1'b0;
            r_out_eof   <= 1'b0;
        end else if (w_out_free) begin
            r_out_valid <= w_move;
            r_out_eof   <= w_move & r_sh_eof & w_cnt_zero;
        end
    end

    assign dataInStop   = w_in_stop;
    assign dataOutValid = r_out_valid;
    assign dataOut      = r_out_data;
    assign dataOutEof   = r_out_eof;

endmodule

// File: tb/tb_smi_self_link_serializer.sv
// Bench for smi_self_link_serializer: vector table, corner sequences,
// and random traffic against a beat-queue reference model.
module tb_smi_self_link_serializer;

    logic        clk = 1'b0;
    logic        srst;
    logic        dataInValid;
    logic [31:0] dataIn;
    logic [1:0]  dataInBeats;
    logic        dataInEof;
    logic        dataInStop;
    logic        dataOutValid;
    logic [7:0]  dataOut;
    logic        dataOutEof;
    logic        dataOutStop;

    smi_self_link_serializer #(
        .DataWidth(8),
        .Ratio(4),
        .RatioIndexSize(2)
    ) dut (
        .clk(clk),
        .srst(srst),
        .dataInValid(dataInValid),
        .dataIn(dataIn),
        .dataInBeats(dataInBeats),
        .dataInEof(dataInEof),
        .dataInStop(dataInStop),
        .dataOutValid(dataOutValid),
        .dataOut(dataOut),
        .dataOutEof(dataOutEof),
        .dataOutStop(dataOutStop)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    int total = 0;
    int bad = 0;

    logic [7:0] obs_d[$];
    logic       obs_e[$];
    int         obs_c[$];
    int         acc_c[$];
    logic [8:0] exp_q[$];
    logic       stop_seen = 1'b0;
    logic       prev_hold = 1'b0;
    logic [7:0] prev_d;
    logic       prev_e;

    typedef struct {
        logic [31:0] word;
        logic [1:0]  beats;
        logic        eof;
        int          n;
        logic [31:0] exp;
    } vec_t;

    vec_t vt[5];

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, req);
        end
    endtask

    // Observes both handshakes half a cycle before the edge that completes them
    always @(negedge clk) begin
        if (srst !== 1'b0) begin
            prev_hold = 1'b0;
        end else begin
            if (prev_hold) begin
                chk("hold_valid", 32'(dataOutValid), 32'd1);
                chk("hold_data", 32'(dataOut), 32'(prev_d));
                chk("hold_eof", 32'(dataOutEof), 32'(prev_e));
            end
            if (dataOutValid === 1'b1 && dataOutStop === 1'b0) begin
                obs_d.push_back(dataOut);
                obs_e.push_back(dataOutEof);
                obs_c.push_back(cyc);
            end
            if (dataInValid === 1'b1 && dataInStop === 1'b0) begin
                acc_c.push_back(cyc);
                for (int k = 0; k <= int'(dataInBeats); k++)
                    exp_q.push_back({dataInEof && (k == int'(dataInBeats)),
                                     dataIn[k*8 +: 8]});
            end
            if (dataInStop === 1'b1) stop_seen = 1'b1;
            prev_hold = (dataOutValid === 1'b1 && dataOutStop === 1'b1);
            prev_d = dataOut;
            prev_e = dataOutEof;
        end
    end

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic clear_q();
        obs_d.delete();
        obs_e.delete();
        obs_c.delete();
        acc_c.delete();
        exp_q.delete();
        stop_seen = 1'b0;
    endtask

    task automatic send(input logic [31:0] w, input logic [1:0] b,
                        input logic e);
        dataIn = w;
        dataInBeats = b;
        dataInEof = e;
        dataInValid = 1'b1;
        for (int g = 0; g < 100; g++) begin
            @(negedge clk);
            if (dataInStop === 1'b0) break;
        end
        @(posedge clk);
        #1;
        dataInValid = 1'b0;
    endtask

    task automatic wait_beats(input int n);
        int g;
        for (g = 0; g < 300; g++) begin
            if (obs_d.size() >= n) break;
            @(posedge clk);
            #1;
        end
        if (g == 300) begin
            total++;
            bad++;
            $display("FAIL wait_beats: got %0d beats want %0d",
                     obs_d.size(), n);
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        srst = 1'b1;
        dataInValid = 1'b0;
        dataIn = '0;
        dataInBeats = '0;
        dataInEof = 1'b0;
        dataOutStop = 1'b0;

        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            chk("rst_valid", 32'(dataOutValid), 32'd0);
            chk("rst_eof", 32'(dataOutEof), 32'd0);
            chk("rst_stop", 32'(dataInStop), 32'd0);
        end
        @(posedge clk);
        #1;
        srst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("idle_valid", 32'(dataOutValid), 32'd0);
            chk("idle_stop", 32'(dataInStop), 32'd0);
        end
        @(posedge clk);
        #1;

        vt[0] = '{32'h44332211, 2'd3, 1'b1, 4, 32'h44332211};
        vt[1] = '{32'hDDCCBBAA, 2'd1, 1'b0, 2, 32'h0000BBAA};
        vt[2] = '{32'h000000EE, 2'd0, 1'b1, 1, 32'h000000EE};
        vt[3] = '{32'hCAFEF00D, 2'd2, 1'b1, 3, 32'h00FEF00D};
        vt[4] = '{32'h12345678, 2'd0, 1'b0, 1, 32'h00000078};

        for (int i = 0; i < 5; i++) begin
            logic [31:0] ev;
            ev = vt[i].exp;
            clear_q();
            send(vt[i].word, vt[i].beats, vt[i].eof);
            wait_beats(vt[i].n);
            idle(4);
            chk("vec_count", 32'(obs_d.size()), 32'(vt[i].n));
            for (int k = 0; k < vt[i].n && k < obs_d.size(); k++) begin
                chk("vec_data", 32'(obs_d[k]), 32'(ev[k*8 +: 8]));
                chk("vec_eof", 32'(obs_e[k]),
                    32'(vt[i].eof && (k == vt[i].n - 1)));
                chk("vec_gap", 32'(obs_c[k] - obs_c[0]), 32'(k));
            end
            if (obs_c.size() > 0 && acc_c.size() > 0)
                chk("vec_latency", 32'(obs_c[0] - acc_c[0]), 32'd3);
        end

        clear_q();
        send(32'h04030201, 2'd3, 1'b0);
        send(32'h08070605, 2'd3, 1'b1);
        wait_beats(8);
        idle(4);
        chk("b2b_count", 32'(obs_d.size()), 32'd8);
        for (int k = 0; k < 8 && k < obs_d.size(); k++) begin
            chk("b2b_data", 32'(obs_d[k]), 32'(k + 1));
            chk("b2b_eof", 32'(obs_e[k]), 32'(k == 7));
            chk("b2b_gap", 32'(obs_c[k] - obs_c[0]), 32'(k));
        end
        chk("b2b_stop_seen", 32'(stop_seen), 32'd1);

        clear_q();
        fork
            begin
                send(32'h44332211, 2'd3, 1'b1);
                send(32'h88776655, 2'd3, 1'b1);
            end
        join_none
        wait_beats(1);
        dataOutStop = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("stall_data", 32'(dataOut), 32'h22);
            chk("stall_valid", 32'(dataOutValid), 32'd1);
            chk("stall_instop", 32'(dataInStop), 32'd1);
        end
        @(posedge clk);
        #1;
        dataOutStop = 1'b0;
        wait_beats(8);
        idle(4);
        chk("stall_count", 32'(obs_d.size()), 32'd8);
        for (int k = 0; k < 8 && k < obs_d.size(); k++)
            chk("stall_seq", 32'(obs_d[k]), 32'(8'h11 * (k + 1)));

        clear_q();
        send(32'h44332211, 2'd3, 1'b1);
        wait_beats(1);
        srst = 1'b1;
        idle(2);
        srst = 1'b0;
        chk("mid_rst_valid", 32'(dataOutValid), 32'd0);
        chk("mid_rst_stop", 32'(dataInStop), 32'd0);
        send(32'h000000EE, 2'd0, 1'b1);
        wait_beats(2);
        idle(6);
        chk("mid_rst_count", 32'(obs_d.size()), 32'd2);
        if (obs_d.size() >= 2) begin
            chk("mid_rst_first", 32'(obs_d[0]), 32'h11);
            chk("mid_rst_data", 32'(obs_d[1]), 32'hEE);
            chk("mid_rst_eof", 32'(obs_e[1]), 32'd1);
        end

        clear_q();
        begin
            bit rnd_done;
            rnd_done = 1'b0;
            fork
                begin
                    for (int i = 0; i < 150; i++) begin
                        idle(int'($urandom_range(0, 2)));
                        send($urandom, 2'($urandom_range(0, 3)),
                             1'($urandom_range(0, 1)));
                    end
                    rnd_done = 1'b1;
                end
                begin
                    while (!rnd_done) begin
                        @(posedge clk);
                        #1;
                        dataOutStop = ($urandom_range(0, 3) == 0);
                    end
                    dataOutStop = 1'b0;
                end
            join
        end
        wait_beats(exp_q.size());
        idle(6);
        chk("rnd_count", 32'(obs_d.size()), 32'(exp_q.size()));
        for (int k = 0; k < obs_d.size() && k < exp_q.size(); k++)
            chk("rnd_beat", 32'({obs_e[k], obs_d[k]}), 32'(exp_q[k]));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/smi_self_link_serializer.md
Name: smi_self_link_serializer

Overview:
- SELF link width down-converter (transmit side of a wide-to-narrow link pair).
- Accepts one wide word per transfer from an upstream SELF link and emits it as 1 to Ratio narrow beats, least significant beat first, on a downstream SELF link.
- Carries an end-of-frame flag through to the final beat of each word.
- Placed in front of narrow SMI flit paths; the matching deserializer rebuilds the words at the far end.

Parameters:
- DataWidth, 8: width of one output beat.
- Ratio, 4: number of beats in a full input word; must be 2 or more.
- RatioIndexSize, 2: width that holds the value Ratio-1.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- srst  input  1  synchronous active-high reset.
- dataInValid  input  1  upstream word valid.
- dataIn  input  DataWidth*Ratio  upstream word; beat k is bits [k*DataWidth +: DataWidth].
- dataInBeats  input  RatioIndexSize  number of beats to emit, minus 1.
- dataInEof  input  1  word ends a frame.
- dataInStop  output  1  upstream stall; a function of registered state only.
- dataOutValid  output  1  downstream beat valid; driven directly from a register.
- dataOut  output  DataWidth  downstream beat data; driven directly from a register.
- dataOutEof  output  1  frame end; high only on the final beat of an EOF word.
- dataOutStop  input  1  downstream stall.

Behaviour:
- Handshake: a transfer occurs on a rising edge where valid=1 and stop=0. The sender holds data and control stable while valid=1 and stop=1.
- Pipeline stages:
  - Input register (inValid_q, word, beats, eof).
  - Shifter (shValid_q, shifting word, remaining-beat count, eof).
  - Output register (dataOutValid, dataOut, dataOutEof).
- Input register:
  - dataInStop = inValid_q & shValid_q.
  - When dataInStop=0, the input register captures dataInValid and the data/control fields.
- Shifter load:
  - Loads from the input register when inValid_q=1 and either shValid_q=0 or the shifter's last beat moves to the output register this cycle.
  - On load, the remaining count is set to dataInBeats, and inValid_q clears unless a new word is captured on the same edge.
- Beat move:
  - When shValid_q=1 and ~(dataOutValid & dataOutStop), the shifter's low DataWidth bits go to dataOut.
  - The word then shifts right by DataWidth.
  - If the remaining count is 0, shValid_q clears; otherwise the count decrements.
  - dataOutEof is the word's eof ANDed with (remaining count == 0).
- Output register:
  - When ~(dataOutValid & dataOutStop) and no beat moves in, dataOutValid clears.
  - While dataOutValid & dataOutStop, dataOut and dataOutEof hold.
- Latency: a word accepted on edge t with an empty pipeline shows its first beat on dataOut after edge t+2.
- Throughput:
  - Sustains 1 beat/cycle for back-to-back words with beats >= 2.
  - A 1-beat word may insert one idle cycle before the next.
- Width rules:
  - dataInBeats ranges over 0..Ratio-1 (1..Ratio beats).
  - Beats beyond the count are discarded; upper word bits are ignored.
  - Counters are RatioIndexSize bits and never wrap below 0.
- Simultaneous events: in the same cycle, the shifter's last beat can leave, the input word can load into the shifter, and a new upstream word can be captured. No beat is lost or duplicated.
- Reset:
  - srst clears inValid_q, shValid_q, dataOutValid and dataOutEof to 0; dataInStop is therefore 0 after reset.
  - Data registers are not reset.
  - Reset mid-word discards all partial state; the next word after reset starts at beat 0.

Test Plan:
- Reset then idle: srst for 2 cycles -> dataOutValid=0, dataOutEof=0, dataInStop=0 on every cycle.
- Single full word: dataIn=0x44332211, beats=3, eof=1, dataOutStop=0 -> dataOut 0x11,0x22,0x33,0x44 on consecutive cycles; first beat 2 edges after acceptance; dataOutEof=1 only with 0x44.
- Partial word: dataIn=0xDDCCBBAA, beats=1, eof=0 -> exactly 0xAA then 0xBB; dataOutEof=0 throughout.
- Back-to-back full words: 0x04030201 then 0x08070605 (beats=3) -> 8 contiguous beats 0x01..0x08 with no gap; dataInStop pulses high while both words are held.
- Downstream stall: dataOutStop=1 for 5 cycles in mid-word after beat 0x22 -> dataOut holds 0x22 and dataInStop stays high; on release, 0x33 and 0x44 follow with no loss or duplication.
- Reset mid-word: srst asserted after beat 0x11 of 0x44332211, then word 0x000000EE (beats=0, eof=1) sent -> single beat 0xEE with dataOutEof=1; no remnants of the first word.
